// File: rtl/sfifo_pkg.sv
// sfifo shared constants: default geometry and derived widths.
// Pointer width is log2(depth); count width is one bit wider.
package sfifo_pkg;

  localparam int DWIDTH_DEF = 16;
  localparam int DEPTH_DEF  = 16;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  localparam int PTR_W = ptr_w(DEPTH_DEF);
  localparam int CNT_W = PTR_W + 1;

endpackage

// File: rtl/sfifo_mem.sv
// sfifo storage: DEPTH x DWIDTH register array, no reset.
// Ports: clk; we/waddr/wdata sync write; re/raddr -> rdata sync read.
module sfifo_mem #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  // Same-address read/write returns the old word (full FIFO rd+wr).
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sfifo.sv
// sfifo: synchronous FIFO, circular buffer with count and error flags.
// Ports: clk, rst (sync, active-high); wr/din/full/ovfl write side;
// rd/dout/empty/udfl read side. Macro SFIFO_STICKY_ERR_EN makes
// ovfl/udfl sticky until reset; otherwise they pulse for one cycle.
module sfifo
  import sfifo_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DWIDTH-1:0] din,
  output logic              full,
  output logic              ovfl,
  input  logic              rd,
  output logic [DWIDTH-1:0] dout,
  output logic              empty,
  output logic              udfl
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic              rd_ok;
  logic              wr_ok;
  logic              ovfl_evt;
  logic              udfl_evt;
  logic              vld;
  logic [DWIDTH-1:0] rdata;

  assign rd_ok    = rd & ~empty;
  assign wr_ok    = wr & (~full | rd_ok);
  assign ovfl_evt = wr & full & ~rd_ok;
  assign udfl_evt = rd & empty;

  always_comb begin
    cnt_nxt = cnt;
    unique case ({wr_ok, rd_ok})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      ovfl  <= 1'b0;
      udfl  <= 1'b0;
      vld   <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      if (rd_ok) vld  <= 1'b1;
      cnt   <= cnt_nxt;
      empty <= (cnt_nxt == '0);
      full  <= (cnt_nxt == CW'(DEPTH));
`ifdef SFIFO_STICKY_ERR_EN
      ovfl  <= ovfl | ovfl_evt;
      udfl  <= udfl | udfl_evt;
`else
      ovfl  <= ovfl_evt;
      udfl  <= udfl_evt;
`endif
    end
  end

  sfifo_mem #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok & ~rst),
    .waddr (wptr),
    .wdata (din),
    .re    (rd_ok & ~rst),
    .raddr (rptr),
    .rdata (rdata)
  );

  // Array has no reset; vld forces dout to zero until the first read.
  assign dout = vld ? rdata : '0;

endmodule

// File: tb/tb_sfifo.sv
// tb_sfifo: directed self-checking bench for sfifo (default build).
// A small queue model tracks order, full and empty.
module tb_sfifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic [15:0] din;
  logic        full;
  logic        ovfl;
  logic        rd;
  logic [15:0] dout;
  logic        empty;
  logic        udfl;

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] q[$];

  always #5 clk = ~clk;

  sfifo dut (
    .clk   (clk),
    .rst   (rst),
    .wr    (wr),
    .din   (din),
    .full  (full),
    .ovfl  (ovfl),
    .rd    (rd),
    .dout  (dout),
    .empty (empty),
    .udfl  (udfl)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h exp %h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic w, input logic r,
                     input logic [15:0] d);
    bit ra;
    bit wa;
    logic [15:0] e;
    wr = w; rd = r; din = d;
    step;
    wr = 1'b0; rd = 1'b0;
    ra = r && (q.size() > 0);
    wa = w && ((q.size() < 16) || ra);
    if (ra) begin
      e = q.pop_front();
      check("dout", dout, e);
    end
    if (wa) q.push_back(d);
    check("empty", empty, q.size() == 0);
    check("full", full, q.size() == 16);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; din = '0;
    step; step;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovfl", ovfl, 0);
    check("rst_udfl", udfl, 0);
    check("rst_dout", dout, 0);
    rst = 1'b0;

    cyc(1, 0, 16'h0000);
    check("w0_empty", empty, 0);
    cyc(0, 1, 16'h0000);
    check("r0_dout", dout, 16'h0000);
    check("r0_empty", empty, 1);

    for (int i = 1; i <= 16; i++) cyc(1, 0, 16'(i));
    check("fill_full", full, 1);
    cyc(1, 0, 16'hFFFF);
    check("ovfl_set", ovfl, 1);
    check("ovfl_full", full, 1);
    cyc(0, 0, 16'h0);
    check("ovfl_pulse", ovfl, 0);
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 1, 16'h0);
      check("drain", dout, 16'(i));
    end
    check("drain_empty", empty, 1);

    cyc(0, 1, 16'h0);
    check("udfl_set", udfl, 1);
    check("udfl_dout", dout, 16'h0010);
    check("udfl_empty", empty, 1);
    cyc(0, 0, 16'h0);
    check("udfl_pulse", udfl, 0);

    cyc(1, 1, 16'h00AA);
    check("rw_e_udfl", udfl, 1);
    check("rw_e_dout", dout, 16'h0010);
    check("rw_e_empty", empty, 0);
    cyc(0, 1, 16'h0);
    check("rw_e_read", dout, 16'h00AA);

    for (int i = 0; i < 15; i++) cyc(1, 0, 16'h0100 + 16'(i));
    check("f15_full", full, 0);
    for (int i = 0; i < 40; i++)
      cyc(1, 1, 16'h0200 + 16'(i));
    cyc(1, 0, 16'h0300);
    check("f16_full", full, 1);
    cyc(1, 1, 16'h0301);
    check("rwf_full", full, 1);
    check("rwf_ovfl", ovfl, 0);
    check("rwf_dout", dout, 16'h0219);
    while (q.size() > 0) cyc(0, 1, 16'h0);

    for (int i = 0; i < 5; i++) cyc(1, 0, 16'h0400 + 16'(i));
    rst = 1'b1; wr = 1'b1; rd = 1'b1; din = 16'h0BAD;
    step;
    rst = 1'b0; wr = 1'b0; rd = 1'b0;
    q.delete();
    check("mrst_empty", empty, 1);
    check("mrst_full", full, 0);
    check("mrst_dout", dout, 0);
    cyc(0, 1, 16'h0);
    check("mrst_udfl", udfl, 1);
    check("mrst_rdout", dout, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sfifo.md
SFIFO -- requirements
Module: sfifo

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 Parameter DWIDTH, default 16, data word width in bits.
REQ-003 Parameter DEPTH, default 16, number of entries; power of two, at least 2.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 wr  input  1  write request, sampled on rising clk.
REQ-007 din  input  DWIDTH  write data, captured with an accepted write.
REQ-008 full  output  1  registered flag; high when occupancy equals DEPTH.
REQ-009 ovfl  output  1  registered overflow error flag.
REQ-010 rd  input  1  read request, sampled on rising clk.
REQ-011 dout  output  DWIDTH  registered read data.
REQ-012 empty  output  1  registered flag; high when occupancy is 0.
REQ-013 udfl  output  1  registered underflow error flag.

Function
REQ-014 Storage SHALL be a circular buffer of DEPTH words, with write pointer, read pointer and a count of width log2(DEPTH)+1.
REQ-015 A read SHALL be accepted iff rd=1 and empty=0.
REQ-016 A write SHALL be accepted iff wr=1 and either full=0, or full=1 with a read accepted in the same cycle.
REQ-017 An accepted write SHALL store din at the write pointer and advance the pointer modulo DEPTH (wrap from DEPTH-1 to 0).
REQ-018 An accepted read SHALL load dout with the word at the read pointer on that same edge (one-cycle latency) and advance the read pointer modulo DEPTH.
REQ-019 dout SHALL hold its value in any cycle without an accepted read.
REQ-020 Count update: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
REQ-021 full and empty SHALL be updated on the same edge as count: full=(next count==DEPTH), empty=(next count==0).
REQ-022 A write into an empty FIFO SHALL clear empty on that edge; the word is readable on the next cycle.
REQ-023 Simultaneous rd and wr while empty: the write SHALL be accepted, the read rejected, and udfl raised.
REQ-024 wr=1 with full=1 and no accepted read SHALL drop din, leave state unchanged, and raise ovfl.
REQ-025 rd=1 with empty=1 SHALL leave pointers and dout unchanged and raise udfl.

Reset
REQ-026 While rst=1 at a rising edge, the block SHALL set pointers=0, count=0, empty=1, full=0, ovfl=0, udfl=0 and dout=0.
REQ-027 Reset SHALL override any simultaneous rd or wr, including mid-operation; buffered data is discarded.
REQ-028 Storage array contents SHALL NOT be reset.

Configuration
REQ-029 With macro SFIFO_STICKY_ERR_EN defined, ovfl and udfl SHALL be sticky: once set, each stays 1 until reset.
REQ-030 Without SFIFO_STICKY_ERR_EN, ovfl and udfl SHALL each be a one-cycle pulse, asserted in the cycle after the offending request.

Structure
REQ-031 A shared package sfifo_pkg SHALL hold DWIDTH/DEPTH default constants and the derived pointer and count width constants.
REQ-032 Storage SHALL be a sub-module sfifo_mem: a register array with one synchronous write port and one synchronous read port, no reset.
REQ-033 Pointer, count, flag and error logic SHALL reside in sfifo.

Verification
REQ-034 Reset held 2 cycles -> empty=1, full=0, ovfl=0, udfl=0, dout=0.
REQ-035 Write 0x0000 one cycle, then read one cycle -> empty falls after the write; dout=0x0000 after the read edge; empty=1 again.
REQ-036 Write 0x0001..0x0010 (16 words) -> full=1 after the 16th; a 17th write of 0xFFFF -> ovfl asserted, data dropped; 16 reads return 0x0001..0x0010 in order.
REQ-037 Read when empty -> udfl asserted; dout and empty unchanged.
REQ-038 Fill to 15, interleave 40 writes/reads crossing the pointer wrap -> strict FIFO order maintained; simultaneous rd+wr on full keeps full=1.
REQ-039 Assert rst with 5 entries stored -> empty=1 on the next edge; a subsequent read raises udfl.
